// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader
// Purpose  : Serial boot loader for the instruction ROM. After a start
//            request it deserialises MSB-first words from (sin, sin_valid),
//            writes each completed word to consecutive ROM addresses from 0,
//            and holds the Computer in reset for the whole load session.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WORD      instruction word width in bits
//   ADDRW     instruction ROM address width in bits
// Ports
//   clock     in   1      rising-edge clock for all state
//   reset     in   1      asynchronous, active-high reset
//   start     in   1      one-cycle request to begin a load session
//   length    in   ADDRW  number of words to load (sampled on start)
//   sin       in   1      serial data bit, MSB first
//   sin_valid in   1      qualifies sin for one clock
//   romAddr   out  ADDRW  ROM write address
//   romIn     out  WORD   ROM write data
//   romLoad   out  1      ROM write strobe, one cycle per word
//   cpuReset  out  1      holds the Computer in reset while high
//   busy      out  1      high while a load session is active
//   done      out  1      one-cycle pulse when a session completes
//   overrun   out  1      sticky: a serial bit arrived while it could not
//                         be accepted and was dropped
// ============================================================================
module rom_loader #(
  parameter int WORD  = 16,
  parameter int ADDRW = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [ADDRW-1:0] length,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [ADDRW-1:0] romAddr,
  output logic [WORD-1:0]  romIn,
  output logic             romLoad,
  output logic             cpuReset,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  // Bit counter only has to reach WORD-1 before the word is written.
  localparam int BCW = (WORD > 1) ? $clog2(WORD) : 1;

  localparam logic [BCW-1:0] c_bit_last = BCW'(WORD - 1);
  localparam logic [BCW-1:0] c_bit_one  = BCW'(1);
  localparam logic [ADDRW-1:0] c_addr_one = ADDRW'(1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_shift = 2'd1;
  localparam logic [1:0] c_write = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  logic [1:0]       r_state;
  logic [ADDRW-1:0] r_len;
  logic [ADDRW-1:0] r_wcnt;
  logic [BCW-1:0]   r_bcnt;
  logic [WORD-1:0]  r_sreg;

  logic [1:0]       w_state_nxt;
  logic             w_start_ok;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_final_word;
  logic             w_drop;
  logic [WORD-1:0]  w_sreg_nxt;
  logic [ADDRW-1:0] w_wcnt_inc;

  // start is only honoured from IDLE; anywhere else it has no effect.
  assign w_start_ok   = start && (r_state == c_idle);
  assign w_accept     = sin_valid && (r_state == c_shift);
  assign w_last_bit   = (r_bcnt == c_bit_last);
  assign w_sreg_nxt   = {r_sreg[WORD-2:0], sin};
  assign w_wcnt_inc   = r_wcnt + c_addr_one;
  // wcnt+1 never exceeds the captured length, so an ADDRW-bit compare
  // is exact even for the largest length (no wrap to address 0).
  assign w_final_word = (w_wcnt_inc == r_len);
  // Bits offered while the word is being written or the session is closing
  // cannot be shifted in; they are discarded and flagged.
  assign w_drop       = sin_valid && ((r_state == c_write) || (r_state == c_done));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (start) begin
          w_state_nxt = (length == '0) ? c_done : c_shift;
        end
      end
      c_shift: begin
        if (w_accept && w_last_bit) begin
          w_state_nxt = c_write;
        end
      end
      c_write: begin
        w_state_nxt = w_final_word ? c_done : c_shift;
      end
      c_done: begin
        w_state_nxt = c_idle;
      end
      default: begin
        w_state_nxt = c_idle;
      end
    endcase
  end

  // Control state and session counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_idle;
      r_len   <= '0;
      r_wcnt  <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_len  <= length;
        r_wcnt <= '0;
        r_bcnt <= '0;
      end else if (r_state == c_write) begin
        r_bcnt <= '0;
        r_wcnt <= w_wcnt_inc;
      end else if (w_accept) begin
        r_bcnt <= r_bcnt + c_bit_one;
      end
    end
  end

  // Deserialiser.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sreg <= '0;
    end else if (w_accept) begin
      r_sreg <= w_sreg_nxt;
    end
  end

  // Registered outputs. They are decoded from the next state so that each
  // output is valid in the same cycle the FSM occupies the matching state.
  // The ROM address/data are loaded on the edge that accepts the final bit,
  // which gives the one-cycle word latency, and then simply hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      romAddr  <= '0;
      romIn    <= '0;
      romLoad  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      // The Computer stays in reset while the loader itself is in reset.
      cpuReset <= 1'b1;
    end else begin
      romLoad  <= (w_state_nxt == c_write);
      busy     <= (w_state_nxt != c_idle);
      cpuReset <= (w_state_nxt != c_idle);
      done     <= (w_state_nxt == c_done);
      if (w_accept && w_last_bit) begin
        romAddr <= r_wcnt;
        romIn   <= w_sreg_nxt;
      end
      if (w_start_ok) begin
        overrun <= 1'b0;
      end else if (w_drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_loader
// Purpose  : Self-checking bench for rom_loader. Stimulus pushes expected ROM
//            writes (word index -> address, sent data -> data) and expected
//            done pulses into a scoreboard; a negedge monitor pops and
//            compares whenever the DUT strobes romLoad or done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

  localparam int WORD  = 16;
  localparam int ADDRW = 4;

  logic             clock;
  logic             reset;
  logic             start;
  logic [ADDRW-1:0] length;
  logic             sin;
  logic             sin_valid;
  logic [ADDRW-1:0] romAddr;
  logic [WORD-1:0]  romIn;
  logic             romLoad;
  logic             cpuReset;
  logic             busy;
  logic             done;
  logic             overrun;

  typedef struct {
    logic [ADDRW-1:0] addr;
    logic [WORD-1:0]  data;
  } wr_t;

  wr_t exp_wr_q[$];
  int  exp_done;
  int  n_checks;
  int  n_fail;

  rom_loader #(
    .WORD (WORD),
    .ADDRW(ADDRW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .length   (length),
    .sin      (sin),
    .sin_valid(sin_valid),
    .romAddr  (romAddr),
    .romIn    (romIn),
    .romLoad  (romLoad),
    .cpuReset (cpuReset),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    wr_t e;
    if (romLoad === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write at %0t",
                 romAddr, romIn, $time);
      end else begin
        e = exp_wr_q.pop_front();
        chk("wr_addr", 32'(romAddr), 32'(e.addr));
        chk("wr_data", 32'(romIn), 32'(e.data));
      end
    end
    if (done === 1'b1) begin
      chk("done_expected", 32'(exp_done > 0), 32'd1);
      if (exp_done > 0) exp_done--;
    end
  end

  // Sends one word MSB first with random idle gaps (unqualified sin is
  // randomised). Returns in the cycle after the final bit was accepted,
  // which must be the write cycle.
  task automatic send_word(input logic [WORD-1:0] d, input int maxgap, input int inject);
    int g;
    for (int i = WORD - 1; i >= 0; i--) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) begin
        sin = 1'($urandom);
        tick();
      end
      chk("no_early_load", 32'(romLoad), 32'd0);
      sin       = d[i];
      sin_valid = 1'b1;
      tick();
      sin_valid = 1'b0;
      if ((WORD - i) == inject) begin
        start  = 1'b1;
        length = ADDRW'(5);
        tick();
        start  = 1'b0;
        chk("busy_after_ignored_start", 32'(busy), 32'd1);
      end
    end
    chk("load_latency", 32'(romLoad), 32'd1);
  endtask

  // One complete session. fixed selects the 0x0002/0xEC10 words, ovr holds
  // sin_valid through the first write cycle, inject issues a start while busy.
  task automatic session(input int len, input int maxgap, input bit fixed,
                         input bit ovr, input int inject);
    logic [WORD-1:0] d;
    wr_t e;
    chk("idle_busy", 32'(busy), 32'd0);
    length = ADDRW'(len);
    start  = 1'b1;
    exp_done++;
    tick();
    start  = 1'b0;
    length = ADDRW'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("overrun_clear_on_start", 32'(overrun), 32'd0);
    for (int w = 0; w < len; w++) begin
      if (fixed) d = (w == 0) ? 16'h0002 : 16'hEC10;
      else       d = WORD'($urandom);
      e.addr = ADDRW'(w);
      e.data = d;
      exp_wr_q.push_back(e);
      send_word(d, maxgap, (w == 0) ? inject : -1);
      if (ovr && w == 0) begin
        sin       = 1'b1;
        sin_valid = 1'b1;
      end
      tick();
      sin_valid = 1'b0;
      if (ovr && w == 0) chk("overrun_set", 32'(overrun), 32'd1);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("cpureset_in_done", 32'(cpuReset), 32'd1);
    tick();
    chk("done_cleared", 32'(done), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
    chk("cpureset_released", 32'(cpuReset), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_done  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    length    = '0;
    sin       = 1'b0;
    sin_valid = 1'b0;

    // Reset values, applied asynchronously before any clock edge.
    #1;
    chk("rst_romLoad", 32'(romLoad), 32'd0);
    chk("rst_romAddr", 32'(romAddr), 32'd0);
    chk("rst_romIn", 32'(romIn), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_cpuReset", 32'(cpuReset), 32'd1);
    repeat (2) tick();
    reset = 1'b0;
    chk("cpureset_held_until_edge", 32'(cpuReset), 32'd1);
    tick();
    chk("cpureset_falls_after_release", 32'(cpuReset), 32'd0);
    chk("idle_after_release", 32'(busy), 32'd0);

    // Normal load of two fixed words.
    session(2, 0, 1'b1, 1'b0, -1);
    // Overrun in the first write cycle; second word must be unaffected.
    session(2, 2, 1'b0, 1'b1, -1);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    // Empty load: also shows an accepted start clears overrun.
    session(0, 0, 1'b0, 1'b0, -1);
    chk("overrun_still_clear", 32'(overrun), 32'd0);
    // Start with length 5 during a length-1 session is ignored.
    session(1, 1, 1'b0, 1'b0, 5);
    // Back-to-back bits: load on cycle 17.
    session(1, 0, 1'b0, 1'b0, -1);
    // Random sessions.
    for (int k = 0; k < 4; k++) begin
      session(int'($urandom_range(4, 1)), int'($urandom_range(2, 0)), 1'b0, 1'b0, -1);
    end
    session(2, 0, 1'b0, 1'b1, -1);

    // Reset after 9 bits of word 0: async abort, no write, no done.
    length = ADDRW'(3);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sin       = 1'($urandom);
      sin_valid = 1'b1;
      tick();
      sin_valid = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("abort_romLoad", 32'(romLoad), 32'd0);
    chk("abort_romAddr", 32'(romAddr), 32'd0);
    chk("abort_romIn", 32'(romIn), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_overrun", 32'(overrun), 32'd0);
    chk("abort_cpuReset", 32'(cpuReset), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("abort_cpureset_released", 32'(cpuReset), 32'd0);
    for (int i = 0; i < 7; i++) begin
      sin       = 1'($urandom);
      sin_valid = 1'b1;
      tick();
      sin_valid = 1'b0;
    end
    repeat (3) tick();
    chk("abort_stays_idle", 32'(busy), 32'd0);

    // Largest length: addresses 0 .. 2^ADDRW-2 with no wrap.
    session((1 << ADDRW) - 1, 1, 1'b0, 1'b0, -1);

    repeat (3) tick();
    chk("writes_outstanding", 32'(exp_wr_q.size()), 32'd0);
    chk("dones_outstanding", 32'(exp_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
